z80_mem_arbiter: RTL and testbench
==================================

# z80_mem_arbiter

Shares the single external Z80 memory bus between the translator's instruction fetcher (I port) and the RISC core's load/store unit (D port). Each request is latched at grant and one bus cycle is run on the external bus. Completion is returned to the requester through its wait line. Data requests have priority, bounded by a starvation limit that guarantees fetch forward progress. A watchdog force-completes hung bus cycles.

## Interface
- STARVE_LIMIT, 4: max consecutive D grants while I_MREQ is pending; the next grant goes to I.
- TIMEOUT_CYC, 255: max cycles one bus access may stay in an access state before forced completion.
- CLK  in  1  single clock; all state changes on rising edge.
- RST  in  1  reset, synchronous, active-high.
- flush  in  1  pipeline flush from the RISC core; cancels instruction fetches.
- I_MREQ  in  1  fetch request; I_addr is held stable until I_wait is low.
- I_addr  in  16  fetch address.
- I_wait  out  1  high while a fetch request is pending and not completing this cycle.
- I_data  out  8  fetch data; valid only in the cycle I_wait falls with I_MREQ high.
- D_MREQ  in  1  data request; held with its address and data until D_wait is low.
- D_WR  in  1  1 = write, 0 = read.
- D_addr  in  16  data address.
- D_wdata  in  8  write data.
- D_wait  out  1  high while D_MREQ is pending and not completing this cycle.
- D_rdata  out  8  read data; valid in the D completion cycle.
- M_MREQ  out  1  external bus cycle active.
- M_RD, M_WR  out  1 each  external read / write strobe.
- M_addr  out  16  external address (registered).
- M_wdata  out  8  external write data (registered).
- M_rdata  in  8  external read data.
- M_wait  in  1  external wait; the access completes in the first M_MREQ cycle with M_wait=0.
- bus_err  out  1  sticky flag: a watchdog timeout occurred.

## Operation
- FSM states: IDLE, I_ACC, D_ACC.
- In IDLE, arbitrate each cycle. Effective fetch request: I_req = I_MREQ & ~flush.
  - If D_MREQ and (~I_req or streak < STARVE_LIMIT): go to D_ACC.
  - Else if I_req: go to I_ACC.
  - Else stay in IDLE.
- At grant, latch the address into M_addr. For D grants, also latch D_wdata and D_WR.
- streak (3-bit minimum, saturating at STARVE_LIMIT):
  - On a D grant with I_req high: increment.
  - On a D grant with I_req low: clear to 0.
  - On an I grant: clear to 0.
- Access state outputs: M_MREQ=1; M_RD = ~wr; M_WR = wr (wr = 0 for I_ACC).
- Completion (M_wait=0 in an access state):
  - Return to IDLE the next cycle.
  - Pulse the owner's wait low for exactly this cycle.
  - Pass M_rdata combinationally to I_data or D_rdata.
- I_wait = I_MREQ & ~(I_ACC & done & ~drop). D_wait = D_MREQ & ~(D_ACC & done).
- Flush during I_ACC:
  - Set a drop flag; the bus cycle runs to completion because it cannot be aborted.
  - On completion I_wait stays high, the data is discarded, and drop clears.
  - D accesses are unaffected by flush.
- Watchdog: a cycle counter clears at grant and increments in the access states. When it reaches TIMEOUT_CYC with M_wait still high:
  - Force completion.
  - Return rdata = 8'hFF.
  - Set bus_err. It stays set until RST.

## Timing
- Reset values: state=IDLE, M_MREQ=0, M_RD=0, M_WR=0, M_addr=0, M_wdata=0, streak=0, drop=0, bus_err=0. During RST, both waits equal their MREQ inputs.
- Reset mid-access: the FSM is in IDLE on the cycle after RST is sampled, with M_MREQ low. No completion is signalled.
- Latency with M_wait=0:
  - Request seen in IDLE at cycle n.
  - Access and completion at n+1.
  - IDLE at n+2.
  - Each M_wait cycle adds 1 cycle.
- Throughput: one access per 2 cycles maximum. The IDLE turnaround cycle is mandatory.
- Requesters must not drop MREQ or change address/data while their wait is high. Dropping MREQ during a granted access leaves the bus cycle to complete; the result is discarded.
- Simultaneous requests: D wins unless streak = STARVE_LIMIT.
- flush and an I completion in the same cycle: the completion is suppressed (I_wait stays 1).

## Test plan
- Single fetch, I_addr=16'h0100, M_wait=0, M_rdata=8'h3E -> M_MREQ and M_RD high at cycle 1 with M_addr=16'h0100; I_wait low and I_data=8'h3E at cycle 1; IDLE at cycle 2.
- D write, D_addr=16'hC000, D_wdata=8'h5A, M_wait high for 3 cycles -> M_WR held for 4 cycles; D_wait low only in the 4th cycle.
- I_MREQ and D_MREQ held continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I…; every other cycle is IDLE.
- flush pulsed in the 2nd cycle of an I_ACC with M_wait=1 for 3 cycles -> bus cycle completes; I_wait never falls; the next I grant uses the new I_addr.
- M_wait stuck high, TIMEOUT_CYC=255 -> forced completion 255 cycles after grant; D_rdata=8'hFF; bus_err=1 until RST.
- RST asserted during D_ACC -> next cycle IDLE with M_MREQ=0, streak=0, bus_err=0; D_wait follows D_MREQ.

Source files
------------

// File: rtl/z80_mem_arbiter.sv
// Arbitrates the shared Z80 memory bus between the instruction fetcher (I) and the
// load/store unit (D). D has priority, bounded by a starvation limit, and hung cycles are cut off by a watchdog.
module z80_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT_CYC  = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        flush,
    input  logic        I_MREQ,
    input  logic [15:0] I_addr,
    output logic        I_wait,
    output logic [7:0]  I_data,
    input  logic        D_MREQ,
    input  logic        D_WR,
    input  logic [15:0] D_addr,
    input  logic [7:0]  D_wdata,
    output logic        D_wait,
    output logic [7:0]  D_rdata,
    output logic        M_MREQ,
    output logic        M_RD,
    output logic        M_WR,
    output logic [15:0] M_addr,
    output logic [7:0]  M_wdata,
    input  logic [7:0]  M_rdata,
    input  logic        M_wait,
    output logic        bus_err
);

    localparam int unsigned SW = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;
    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, I_ACC, D_ACC} state_e;

    state_e          state_q;
    logic            mreq_q, rd_q, wr_q;
    logic [15:0]     addr_q;
    logic [7:0]      wdata_q;
    logic [SW-1:0]   streak_q;
    logic [CW-1:0]   cnt_q;
    logic            drop_q;
    logic            err_q;

    logic            i_req, d_grant, in_acc, timeout, done;
    logic [7:0]      rdata;

    always_comb begin
        i_req   = I_MREQ & ~flush;
        d_grant = D_MREQ & (~i_req | (streak_q < SW'(STARVE_LIMIT)));
        in_acc  = (state_q != IDLE);
        // cnt_q holds completed access cycles, so the forced completion lands on access cycle TIMEOUT_CYC
        timeout = in_acc & M_wait & (cnt_q == CW'(TIMEOUT_CYC - 1));
        done    = in_acc & ~RST & (~M_wait | timeout);
        rdata   = timeout ? 8'hFF : M_rdata;
        // A flush coinciding with the fetch completion suppresses it just like a pending drop
        I_wait  = I_MREQ & ~((state_q == I_ACC) & done & ~drop_q & ~flush);
        D_wait  = D_MREQ & ~((state_q == D_ACC) & done);
    end

    assign I_data  = rdata;
    assign D_rdata = rdata;
    assign M_MREQ  = mreq_q;
    assign M_RD    = rd_q;
    assign M_WR    = wr_q;
    assign M_addr  = addr_q;
    assign M_wdata = wdata_q;
    assign bus_err = err_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            mreq_q   <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            streak_q <= '0;
            cnt_q    <= '0;
            drop_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q  <= '0;
                    drop_q <= 1'b0;
                    if (d_grant) begin
                        state_q <= D_ACC;
                        mreq_q  <= 1'b1;
                        rd_q    <= ~D_WR;
                        wr_q    <= D_WR;
                        addr_q  <= D_addr;
                        wdata_q <= D_wdata;
                        if (i_req)
                            streak_q <= (streak_q < SW'(STARVE_LIMIT)) ? streak_q + SW'(1) : streak_q;
                        else
                            streak_q <= '0;
                    end else if (i_req) begin
                        state_q  <= I_ACC;
                        mreq_q   <= 1'b1;
                        rd_q     <= 1'b1;
                        wr_q     <= 1'b0;
                        addr_q   <= I_addr;
                        streak_q <= '0;
                    end
                end
                I_ACC, D_ACC: begin
                    if (done) begin
                        state_q <= IDLE;
                        mreq_q  <= 1'b0;
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        drop_q  <= 1'b0;
                        err_q   <= err_q | timeout;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                        if (state_q == I_ACC && flush)
                            drop_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    mreq_q  <= 1'b0;
                    rd_q    <= 1'b0;
                    wr_q    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_z80_mem_arbiter.sv
// Directed bench for z80_mem_arbiter: fetch, write with waits, starvation order,
// flush drop, watchdog timeout and reset mid-access.
module tb_z80_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        flush = 1'b0;
    logic        I_MREQ = 1'b0;
    logic [15:0] I_addr = '0;
    logic        I_wait;
    logic [7:0]  I_data;
    logic        D_MREQ = 1'b0;
    logic        D_WR = 1'b0;
    logic [15:0] D_addr = '0;
    logic [7:0]  D_wdata = '0;
    logic        D_wait;
    logic [7:0]  D_rdata;
    logic        M_MREQ, M_RD, M_WR;
    logic [15:0] M_addr;
    logic [7:0]  M_wdata;
    logic [7:0]  M_rdata = '0;
    logic        M_wait = 1'b0;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    z80_mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYC(255)) dut (
        .CLK(CLK), .RST(RST), .flush(flush),
        .I_MREQ(I_MREQ), .I_addr(I_addr), .I_wait(I_wait), .I_data(I_data),
        .D_MREQ(D_MREQ), .D_WR(D_WR), .D_addr(D_addr), .D_wdata(D_wdata),
        .D_wait(D_wait), .D_rdata(D_rdata),
        .M_MREQ(M_MREQ), .M_RD(M_RD), .M_WR(M_WR), .M_addr(M_addr),
        .M_wdata(M_wdata), .M_rdata(M_rdata), .M_wait(M_wait), .bus_err(bus_err)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        RST = 1'b1; I_MREQ = 1'b1; D_MREQ = 1'b0;
        tick; tick; #1;
        checks++;
        if ({M_MREQ, M_RD, M_WR, M_addr, M_wdata, bus_err} !== 28'h0) begin
            errors++; $display("FAIL reset_bus: got %h expected 0", {M_MREQ, M_RD, M_WR, M_addr, M_wdata, bus_err});
        end
        checks++;
        if ({I_wait, D_wait} !== 2'b10) begin
            errors++; $display("FAIL reset_waits_a: got %b expected 10", {I_wait, D_wait});
        end
        I_MREQ = 1'b0; D_MREQ = 1'b1; #1;
        checks++;
        if ({I_wait, D_wait} !== 2'b01) begin
            errors++; $display("FAIL reset_waits_b: got %b expected 01", {I_wait, D_wait});
        end
        tick;
        RST = 1'b0; D_MREQ = 1'b0; #1;
        checks++;
        if (M_MREQ !== 1'b0) begin
            errors++; $display("FAIL reset_idle: M_MREQ got %b expected 0", M_MREQ);
        end
    endtask

    task automatic test_single_fetch;
        tick;
        I_MREQ = 1'b1; I_addr = 16'h0100; M_wait = 1'b0; M_rdata = 8'h3E; #1;
        checks++;
        if ({M_MREQ, I_wait} !== 2'b01) begin
            errors++; $display("FAIL fetch_c0: got %b expected 01", {M_MREQ, I_wait});
        end
        tick; #1;
        checks++;
        if ({M_MREQ, M_RD, M_WR, M_addr} !== {1'b1, 1'b1, 1'b0, 16'h0100}) begin
            errors++; $display("FAIL fetch_bus: got %h expected %h", {M_MREQ, M_RD, M_WR, M_addr}, {1'b1, 1'b1, 1'b0, 16'h0100});
        end
        checks++;
        if ({I_wait, I_data} !== {1'b0, 8'h3E}) begin
            errors++; $display("FAIL fetch_data: got %h expected %h", {I_wait, I_data}, {1'b0, 8'h3E});
        end
        tick;
        I_MREQ = 1'b0; #1;
        checks++;
        if (M_MREQ !== 1'b0) begin
            errors++; $display("FAIL fetch_idle: M_MREQ got %b expected 0", M_MREQ);
        end
    endtask

    task automatic test_d_write;
        tick;
        D_MREQ = 1'b1; D_WR = 1'b1; D_addr = 16'hC000; D_wdata = 8'h5A; M_wait = 1'b1; #1;
        checks++;
        if ({M_MREQ, D_wait} !== 2'b01) begin
            errors++; $display("FAIL dwr_c0: got %b expected 01", {M_MREQ, D_wait});
        end
        for (int i = 1; i <= 4; i++) begin
            tick;
            M_wait = (i < 4); #1;
            checks++;
            if ({M_MREQ, M_RD, M_WR, M_addr, M_wdata} !== {1'b1, 1'b0, 1'b1, 16'hC000, 8'h5A}) begin
                errors++; $display("FAIL dwr_bus c%0d: got %h expected %h", i, {M_MREQ, M_RD, M_WR, M_addr, M_wdata}, {1'b1, 1'b0, 1'b1, 16'hC000, 8'h5A});
            end
            checks++;
            if (D_wait !== (i < 4)) begin
                errors++; $display("FAIL dwr_wait c%0d: got %b expected %b", i, D_wait, (i < 4));
            end
        end
        tick;
        D_MREQ = 1'b0; D_WR = 1'b0; M_wait = 1'b0; #1;
        checks++;
        if (M_MREQ !== 1'b0) begin
            errors++; $display("FAIL dwr_idle: M_MREQ got %b expected 0", M_MREQ);
        end
    endtask

    task automatic test_starvation;
        logic        is_i;
        logic [15:0] exp_addr;
        tick;
        I_MREQ = 1'b1; I_addr = 16'h1234; D_MREQ = 1'b1; D_WR = 1'b0; D_addr = 16'h8000;
        M_wait = 1'b0; M_rdata = 8'hA5;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (k % 2 == 0) begin
                checks++;
                if ({M_MREQ, I_wait, D_wait} !== 3'b011) begin
                    errors++; $display("FAIL starve_idle k%0d: got %b expected 011", k, {M_MREQ, I_wait, D_wait});
                end
            end else begin
                is_i = (((k - 1) / 2) % 5 == 4);
                exp_addr = is_i ? 16'h1234 : 16'h8000;
                checks++;
                if ({M_MREQ, M_addr, I_wait, D_wait} !== {1'b1, exp_addr, ~is_i, is_i}) begin
                    errors++; $display("FAIL starve_grant k%0d: got %h expected %h", k, {M_MREQ, M_addr, I_wait, D_wait}, {1'b1, exp_addr, ~is_i, is_i});
                end
            end
            tick;
        end
        I_MREQ = 1'b0; D_MREQ = 1'b0; #1;
        checks++;
        if (M_MREQ !== 1'b0) begin
            errors++; $display("FAIL starve_end: M_MREQ got %b expected 0", M_MREQ);
        end
    endtask

    task automatic test_flush;
        tick;
        I_MREQ = 1'b1; I_addr = 16'h0200; M_wait = 1'b1; flush = 1'b0; M_rdata = 8'h11; #1;
        for (int c = 1; c <= 5; c++) begin
            tick;
            flush = (c == 2);
            if (c == 2) I_addr = 16'h0300;
            M_wait = (c < 4); #1;
            checks++;
            if ({I_wait, M_MREQ, M_addr} !== {1'b1, (c <= 4), 16'h0200}) begin
                errors++; $display("FAIL flush_drop c%0d: got %h expected %h", c, {I_wait, M_MREQ, M_addr}, {1'b1, (c <= 4), 16'h0200});
            end
        end
        tick;
        M_rdata = 8'hC9; #1;
        checks++;
        if ({M_MREQ, M_addr, I_wait, I_data} !== {1'b1, 16'h0300, 1'b0, 8'hC9}) begin
            errors++; $display("FAIL flush_refetch: got %h expected %h", {M_MREQ, M_addr, I_wait, I_data}, {1'b1, 16'h0300, 1'b0, 8'hC9});
        end
        tick;
        I_MREQ = 1'b0; #1;
        tick;
        I_MREQ = 1'b1; I_addr = 16'h0400; M_wait = 1'b0; #1;
        tick;
        flush = 1'b1; #1;
        checks++;
        if ({M_MREQ, I_wait} !== 2'b11) begin
            errors++; $display("FAIL flush_same_cycle: got %b expected 11", {M_MREQ, I_wait});
        end
        tick;
        flush = 1'b0; #1;
        checks++;
        if ({M_MREQ, I_wait} !== 2'b01) begin
            errors++; $display("FAIL flush_after: got %b expected 01", {M_MREQ, I_wait});
        end
        tick; #1;
        checks++;
        if ({M_MREQ, M_addr, I_wait} !== {1'b1, 16'h0400, 1'b0}) begin
            errors++; $display("FAIL flush_retry: got %h expected %h", {M_MREQ, M_addr, I_wait}, {1'b1, 16'h0400, 1'b0});
        end
        tick;
        I_MREQ = 1'b0; #1;
    endtask

    task automatic test_timeout;
        int done_at;
        done_at = 0;
        tick;
        D_MREQ = 1'b1; D_WR = 1'b0; D_addr = 16'h4000; M_wait = 1'b1; M_rdata = 8'h12; #1;
        for (int c = 1; c <= 300; c++) begin
            tick; #1;
            if (D_wait === 1'b0) begin
                done_at = c;
                checks++;
                if ({D_rdata, bus_err} !== {8'hFF, 1'b0}) begin
                    errors++; $display("FAIL timeout_data: got %h expected %h", {D_rdata, bus_err}, {8'hFF, 1'b0});
                end
                break;
            end
        end
        checks++;
        if (done_at !== 255) begin
            errors++; $display("FAIL timeout_cycle: got %0d expected 255", done_at);
        end
        tick;
        D_MREQ = 1'b0; M_wait = 1'b0; I_MREQ = 1'b1; I_addr = 16'h0500; M_rdata = 8'h77; #1;
        checks++;
        if ({M_MREQ, bus_err} !== 2'b01) begin
            errors++; $display("FAIL timeout_err: got %b expected 01", {M_MREQ, bus_err});
        end
        tick; #1;
        checks++;
        if ({I_wait, I_data, bus_err} !== {1'b0, 8'h77, 1'b1}) begin
            errors++; $display("FAIL timeout_sticky: got %h expected %h", {I_wait, I_data, bus_err}, {1'b0, 8'h77, 1'b1});
        end
        tick;
        I_MREQ = 1'b0; #1;
    endtask

    task automatic test_reset_mid;
        tick;
        D_MREQ = 1'b1; D_WR = 1'b0; D_addr = 16'h6000; M_wait = 1'b1; #1;
        tick; #1;
        checks++;
        if ({M_MREQ, D_wait, bus_err} !== 3'b111) begin
            errors++; $display("FAIL rstmid_acc: got %b expected 111", {M_MREQ, D_wait, bus_err});
        end
        tick;
        RST = 1'b1; M_wait = 1'b0; #1;
        checks++;
        if ({D_wait, I_wait} !== 2'b10) begin
            errors++; $display("FAIL rstmid_nocomp: got %b expected 10", {D_wait, I_wait});
        end
        tick;
        RST = 1'b0; #1;
        checks++;
        if ({M_MREQ, M_RD, M_WR, M_addr, bus_err, D_wait} !== {20'h0, 1'b1}) begin
            errors++; $display("FAIL rstmid_idle: got %h expected %h", {M_MREQ, M_RD, M_WR, M_addr, bus_err, D_wait}, {20'h0, 1'b1});
        end
        tick; #1;
        checks++;
        if ({M_MREQ, M_addr, D_wait} !== {1'b1, 16'h6000, 1'b0}) begin
            errors++; $display("FAIL rstmid_regrant: got %h expected %h", {M_MREQ, M_addr, D_wait}, {1'b1, 16'h6000, 1'b0});
        end
        tick;
        D_MREQ = 1'b0; #1;
    endtask

    initial begin
        test_reset;
        test_single_fetch;
        test_d_write;
        test_starvation;
        test_flush;
        test_timeout;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
